// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA timing constants (640x480 raster), the receiver
//               lock state encoding and a saturating counter helper. Used by
//               both the VGA controller and vga_frame_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_DISP   = 640;
    localparam int H_FPORCH = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BPORCH = 48;
    localparam int H_PIXELS = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;

    // Vertical timing, in lines
    localparam int V_DISP   = 480;
    localparam int V_FPORCH = 11;
    localparam int V_SYNC   = 2;
    localparam int V_BPORCH = 31;
    localparam int V_LINES  = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;

    localparam int LOCK_FRAMES = 2;
    localparam int CNT_W       = 11;

    // Receiver lock state encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : vga_edge_det
// Description : Registers an input bus once and flags per-bit rising and
//               falling transitions between the previous and current
//               registered samples.
// Ports       : VGA_CLK  - pixel clock
//               RESET_N  - asynchronous active-low reset
//               din      - raw input
//               q        - registered input
//               rise     - q went 0->1 this cycle
//               fall     - q went 1->0 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module vga_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             VGA_CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cur  <= '0;
            r_prev <= '0;
        end else begin
            r_cur  <= din;
            r_prev <= r_cur;
        end
    end

    assign q    = r_cur;
    assign rise = r_cur & ~r_prev;
    assign fall = ~r_cur & r_prev;

endmodule
`default_nettype wire

// File: rtl/vga_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_receiver
// Description : Monitor-side VGA receiver. Recovers line/frame structure from
//               HS/VS/BLANK_N, emits a coordinate-tagged pixel stream,
//               measures timing, tracks lock and produces a per-frame RGB
//               checksum.
// Ports       : VGA_CLK, RESET_N           - clock, async active-low reset
//               VGA_HS, VGA_VS             - active-low syncs
//               VGA_BLANK_N                - active video flag
//               VGA_R/G/B                  - pixel colour
//               PIX_VALID/PIX_X/PIX_Y/PIX_RGB - registered pixel stream
//               LINE_LEN, FRAME_LINES      - last measured line/frame length
//               FRAME_SUM, FRAME_DONE      - frame checksum and update strobe
//               LOCKED, TIMING_ERR         - lock status and loss-of-lock pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_receiver #(
    parameter int H_DISP      = vga_timing_pkg::H_DISP,
    parameter int V_DISP      = vga_timing_pkg::V_DISP,
    parameter int H_PIXELS    = vga_timing_pkg::H_PIXELS,
    parameter int V_LINES     = vga_timing_pkg::V_LINES,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic        VGA_CLK,
    input  logic        RESET_N,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    output logic        PIX_VALID,
    output logic [10:0] PIX_X,
    output logic [10:0] PIX_Y,
    output logic [23:0] PIX_RGB,
    output logic [10:0] LINE_LEN,
    output logic [10:0] FRAME_LINES,
    output logic [31:0] FRAME_SUM,
    output logic        FRAME_DONE,
    output logic        LOCKED,
    output logic        TIMING_ERR
);

    import vga_timing_pkg::*;

    localparam logic [10:0] c_H_DISP      = 11'(H_DISP);
    localparam logic [10:0] c_V_DISP      = 11'(V_DISP);
    localparam logic [10:0] c_H_PIXELS    = 11'(H_PIXELS);
    localparam logic [10:0] c_V_LINES     = 11'(V_LINES);
    localparam logic [3:0]  c_LOCK_FRAMES = 4'(LOCK_FRAMES);

    // ------------------------------------------------------------------
    // Input stage and edge detection
    // ------------------------------------------------------------------
    logic        w_hs_q_unused, w_hs_rise_unused, w_hs_fall;
    logic        w_vs_q_unused, w_vs_rise_unused, w_vs_fall;
    logic        w_bl, w_bl_rise, w_bl_fall;
    logic [23:0] w_rgb, w_rgb_rise_unused, w_rgb_fall_unused;

    vga_edge_det #(.WIDTH(1)) u_hs (
        .VGA_CLK (VGA_CLK), .RESET_N (RESET_N), .din (VGA_HS),
        .q (w_hs_q_unused), .rise (w_hs_rise_unused), .fall (w_hs_fall)
    );

    vga_edge_det #(.WIDTH(1)) u_vs (
        .VGA_CLK (VGA_CLK), .RESET_N (RESET_N), .din (VGA_VS),
        .q (w_vs_q_unused), .rise (w_vs_rise_unused), .fall (w_vs_fall)
    );

    vga_edge_det #(.WIDTH(1)) u_blank (
        .VGA_CLK (VGA_CLK), .RESET_N (RESET_N), .din (VGA_BLANK_N),
        .q (w_bl), .rise (w_bl_rise), .fall (w_bl_fall)
    );

    vga_edge_det #(.WIDTH(24)) u_rgb (
        .VGA_CLK (VGA_CLK), .RESET_N (RESET_N), .din ({VGA_R, VGA_G, VGA_B}),
        .q (w_rgb), .rise (w_rgb_rise_unused), .fall (w_rgb_fall_unused)
    );

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    logic [10:0] r_hcnt;
    logic        r_hs_seen;     // a previous HS fall exists, so r_hcnt is a real period
    logic [10:0] r_lcnt;
    logic [10:0] r_run;
    logic [10:0] r_act_lines;
    logic        r_frame_ok;    // set at VS fall, cleared by any bad line length or active run
    logic [31:0] r_sum;
    logic [1:0]  r_state;
    logic [3:0]  r_good;

    logic w_line_bad;
    logic w_run_bad;
    logic w_frame_good;
    logic w_lock_loss;

    // The violation terms of the current cycle are folded into the frame
    // verdict so that an HS fall or BLANK fall coincident with the VS fall
    // is charged to the frame that is ending.
    assign w_line_bad   = w_hs_fall && r_hs_seen && (r_hcnt != c_H_PIXELS);
    assign w_run_bad    = w_bl_fall && (r_run != c_H_DISP);
    assign w_frame_good = r_frame_ok && !w_line_bad && !w_run_bad &&
                          (r_lcnt == c_V_LINES) && (r_act_lines == c_V_DISP);
    assign w_lock_loss  = (r_state == ST_LOCK) &&
                          (w_line_bad || w_run_bad || (w_vs_fall && !w_frame_good));

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PIX_VALID <= 1'b0;
            PIX_RGB   <= '0;
            PIX_X     <= '0;
            PIX_Y     <= '0;
        end else begin
            PIX_VALID <= w_bl;
            PIX_RGB   <= w_rgb;
            // X restarts at 0 on the first active pixel and is held at 0 in blanking
            PIX_X     <= (w_bl && !w_bl_rise) ? sat_inc(PIX_X) : '0;
            if (w_vs_fall) begin
                PIX_Y <= '0;
            end else if (w_bl_fall) begin
                PIX_Y <= sat_inc(PIX_Y);
            end
        end
    end

    // ------------------------------------------------------------------
    // Line, frame and active-run counters
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hcnt      <= '0;
            r_hs_seen   <= 1'b0;
            r_lcnt      <= '0;
            r_run       <= '0;
            r_act_lines <= '0;
            r_frame_ok  <= 1'b0;
            LINE_LEN    <= '0;
            FRAME_LINES <= '0;
        end else begin
            if (w_hs_fall) begin
                r_hcnt <= 11'd1;
                if (r_hs_seen) begin
                    LINE_LEN <= r_hcnt;
                end
            end else begin
                r_hcnt <= sat_inc(r_hcnt);
            end

            // Loss of lock restarts line-length measurement from scratch
            if (w_lock_loss) begin
                r_hs_seen <= 1'b0;
            end else if (w_hs_fall) begin
                r_hs_seen <= 1'b1;
            end

            if (w_vs_fall) begin
                FRAME_LINES <= r_lcnt;
                r_lcnt      <= w_hs_fall ? 11'd1 : 11'd0;
            end else if (w_hs_fall) begin
                r_lcnt <= sat_inc(r_lcnt);
            end

            if (w_bl_rise) begin
                r_run <= 11'd1;
            end else if (w_bl) begin
                r_run <= sat_inc(r_run);
            end

            if (w_vs_fall) begin
                r_act_lines <= w_bl_rise ? 11'd1 : 11'd0;
            end else if (w_bl_rise) begin
                r_act_lines <= sat_inc(r_act_lines);
            end

            if (w_vs_fall) begin
                r_frame_ok <= 1'b1;
            end else if (w_line_bad || w_run_bad) begin
                r_frame_ok <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame checksum
    // ------------------------------------------------------------------
    // The running sum restarts on every VS fall, including in SEARCH, so
    // the first published sum already covers a complete frame.
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sum      <= '0;
            FRAME_SUM  <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (w_vs_fall) begin
                r_sum <= w_bl ? {8'd0, w_rgb} : 32'd0;
                if (r_state != ST_SEARCH) begin
                    FRAME_SUM  <= r_sum;
                    FRAME_DONE <= 1'b1;
                end
            end else if (w_bl) begin
                r_sum <= r_sum + {8'd0, w_rgb};
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_SEARCH;
            r_good     <= '0;
            LOCKED     <= 1'b0;
            TIMING_ERR <= 1'b0;
        end else begin
            TIMING_ERR <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (w_vs_fall) begin
                        r_state <= ST_CHECK;
                        r_good  <= '0;
                    end
                end
                ST_CHECK: begin
                    if (w_vs_fall) begin
                        if (w_frame_good) begin
                            r_good <= r_good + 4'd1;
                            if (r_good + 4'd1 == c_LOCK_FRAMES) begin
                                r_state <= ST_LOCK;
                                LOCKED  <= 1'b1;
                            end
                        end else begin
                            r_good <= '0;
                        end
                    end
                end
                ST_LOCK: begin
                    // A coincident VS fall is consumed here; CHECK starts at the next one
                    if (w_lock_loss) begin
                        r_state    <= ST_SEARCH;
                        LOCKED     <= 1'b0;
                        TIMING_ERR <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                    LOCKED  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_receiver
// Description : Directed self-checking bench for vga_frame_receiver using a
//               reduced raster (8x4 active, 12 clocks/line, 6 lines/frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_receiver;

    localparam int HD = 8;
    localparam int HP = 12;
    localparam int VD = 4;
    localparam int VL = 6;

    logic        VGA_CLK     = 1'b0;
    logic        RESET_N     = 1'b0;
    logic        VGA_HS      = 1'b1;
    logic        VGA_VS      = 1'b1;
    logic        VGA_BLANK_N = 1'b0;
    logic [7:0]  VGA_R       = '0;
    logic [7:0]  VGA_G       = '0;
    logic [7:0]  VGA_B       = '0;
    logic        PIX_VALID;
    logic [10:0] PIX_X;
    logic [10:0] PIX_Y;
    logic [23:0] PIX_RGB;
    logic [10:0] LINE_LEN;
    logic [10:0] FRAME_LINES;
    logic [31:0] FRAME_SUM;
    logic        FRAME_DONE;
    logic        LOCKED;
    logic        TIMING_ERR;

    vga_frame_receiver #(
        .H_DISP      (HD),
        .V_DISP      (VD),
        .H_PIXELS    (HP),
        .V_LINES     (VL),
        .LOCK_FRAMES (2)
    ) dut (
        .VGA_CLK     (VGA_CLK),
        .RESET_N     (RESET_N),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .PIX_VALID   (PIX_VALID),
        .PIX_X       (PIX_X),
        .PIX_Y       (PIX_Y),
        .PIX_RGB     (PIX_RGB),
        .LINE_LEN    (LINE_LEN),
        .FRAME_LINES (FRAME_LINES),
        .FRAME_SUM   (FRAME_SUM),
        .FRAME_DONE  (FRAME_DONE),
        .LOCKED      (LOCKED),
        .TIMING_ERR  (TIMING_ERR)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int          total = 0;
    int          bad   = 0;
    int          slot  = 0;           // number of input cycles driven so far
    logic [23:0] hist [0:4095];       // RGB driven in each slot
    int          vs_slot     = 0;     // slot of the last driven VS fall
    int          hs_bad_slot = 0;     // slot of the HS fall ending a stretched line

    // Event record filled from the opposite clock edge
    int          done_cnt = 0, err_cnt = 0;
    int          done_slot = -1, err_slot = -1, lock_rise_slot = -1;
    int          rgb_lat_bad = 0;
    logic        prev_locked = 1'b0;
    int          cap_req = 0, cap_seen = 0;
    logic [10:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
    logic [23:0] first_rgb = '0, last_rgb = '0;

    // Outputs observed at negedge with slot s reflect inputs of slot s-2
    always @(negedge VGA_CLK) begin
        if (FRAME_DONE) begin
            done_cnt++;
            done_slot = slot;
        end
        if (TIMING_ERR) begin
            err_cnt++;
            err_slot = slot;
        end
        if (LOCKED && !prev_locked) lock_rise_slot = slot;
        prev_locked = LOCKED;
        if (PIX_VALID) begin
            if (cap_seen != cap_req) begin
                cap_seen  = cap_req;
                first_x   = PIX_X;
                first_y   = PIX_Y;
                first_rgb = PIX_RGB;
            end
            last_x   = PIX_X;
            last_y   = PIX_Y;
            last_rgb = PIX_RGB;
            if (slot >= 2 && PIX_RGB !== hist[(slot - 2) % 4096]) rgb_lat_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        VGA_HS      = hs;
        VGA_VS      = vs;
        VGA_BLANK_N = bl;
        {VGA_R, VGA_G, VGA_B} = rgb;
        hist[slot % 4096] = rgb;
        @(posedge VGA_CLK);
        #1;
        slot++;
    endtask

    // One source frame: lines 0..3 active (8 px), HS low at clocks 9-10,
    // VS falls together with the HS fall of line 4.
    task automatic send_frame(input int stretch_line, input int short_line,
                              input bit ramp, input bit vs_en);
        int          len, run;
        logic        hs, vs, bl;
        logic [23:0] rgb;
        for (int ln = 0; ln < VL; ln++) begin
            len = (ln == stretch_line) ? HP + 1 : HP;
            run = (ln == short_line) ? HD - 1 : HD;
            for (int c = 0; c < len; c++) begin
                hs = !(c == 9 || c == 10);
                vs = vs_en ? !((ln == 4 && c >= 9) || (ln == 5 && c < 9)) : 1'b1;
                bl = (ln < VD) && (c < run);
                if (!bl)       rgb = 24'hFFFFFF;
                else if (ramp) rgb = {8'(ln + 1), 8'(c + 1), 8'h3C};
                else           rgb = 24'h000001;
                if (vs_en && ln == 4 && c == 9) vs_slot = slot;
                if (ln == stretch_line + 1 && c == 9) hs_bad_slot = slot;
                drive(hs, vs, bl, rgb);
            end
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
        #4 RESET_N = 1'b1;
    endtask

    int d0, e0, v2, v3;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
        chk("rst_pix", {PIX_VALID, PIX_X, PIX_Y}, 32'd0);
        chk("rst_lock", {LOCKED, FRAME_DONE, TIMING_ERR}, 32'd0);
        chk("rst_sum", FRAME_SUM, 32'd0);
        chk("rst_len", {LINE_LEN, FRAME_LINES}, 32'd0);
        #4 RESET_N = 1'b1;

        // ---------------- nominal acquisition ----------------
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("nom_no_done_f0", done_cnt, 0);
        send_frame(-1, -1, 1'b0, 1'b1);
        v2 = vs_slot;
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_done_slot", done_slot, v2 + 2);
        chk("nom_sum", FRAME_SUM, 32);               // 8 px * 4 lines * 1
        chk("nom_unlocked_f1", LOCKED, 0);
        send_frame(-1, -1, 1'b0, 1'b1);
        v3 = vs_slot;
        chk("nom_locked", LOCKED, 1);
        chk("nom_lock_slot", lock_rise_slot, v3 + 2);
        chk("nom_line_len", LINE_LEN, HP);
        chk("nom_frame_lines", FRAME_LINES, VL);

        // ---------------- ramp while locked ----------------
        cap_req++;
        send_frame(-1, -1, 1'b1, 1'b1);
        chk("ramp_first_xy", {first_x, first_y}, 0);
        chk("ramp_last_x", last_x, HD - 1);
        chk("ramp_last_y", last_y, VD - 1);
        chk("ramp_first_rgb", first_rgb, 24'h01013C);
        chk("ramp_last_rgb", last_rgb, 24'h04083C);
        chk("ramp_rgb_latency", rgb_lat_bad, 0);
        // 80*65536 + 144*256 + 32*60
        chk("ramp_sum", FRAME_SUM, 5281664);
        chk("ramp_locked", LOCKED, 1);

        // ---------------- stretched line while locked ----------------
        e0 = err_cnt;
        send_frame(1, -1, 1'b0, 1'b1);
        chk("str_err_cnt", err_cnt - e0, 1);
        chk("str_err_slot", err_slot, hs_bad_slot + 2);
        chk("str_unlocked", LOCKED, 0);
        chk("str_no_done_search", done_cnt, 3);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("str_unlocked_2", LOCKED, 0);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("str_relock", LOCKED, 1);
        chk("str_relock_slot", lock_rise_slot, vs_slot + 2);
        chk("str_err_once", err_cnt - e0, 1);

        // ---------------- async reset mid-line ----------------
        for (int c = 0; c < 5; c++) drive(1'b1, 1'b1, 1'b1, 24'h000001);
        chk("mid_pre_valid", PIX_VALID, 1);
        #1 RESET_N = 1'b0;
        #1;
        chk("mid_rst_ctl", {PIX_VALID, PIX_X, PIX_Y, LOCKED, FRAME_DONE, TIMING_ERR}, 32'd0);
        chk("mid_rst_rgb", PIX_RGB, 32'd0);
        chk("mid_rst_len", {LINE_LEN, FRAME_LINES}, 32'd0);
        chk("mid_rst_sum", FRAME_SUM, 32'd0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
        #4 RESET_N = 1'b1;
        d0 = done_cnt;
        send_frame(-1, -1, 1'b0, 1'b1);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("mid_done_cnt", done_cnt - d0, 1);
        chk("mid_done_slot", done_slot, vs_slot + 2);
        chk("mid_sum", FRAME_SUM, 32);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("mid_lock_slot", lock_rise_slot, vs_slot + 2);

        // ---------------- short active run during CHECK ----------------
        do_reset();
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(-1, -1, 1'b0, 1'b1);
        send_frame(-1, 1, 1'b0, 1'b1);
        chk("short_done", done_cnt - d0, 1);
        chk("short_sum", FRAME_SUM, 31);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("short_not_yet", LOCKED, 0);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("short_locked", LOCKED, 1);
        chk("short_lock_slot", lock_rise_slot, vs_slot + 2);
        chk("short_no_err", err_cnt - e0, 0);

        // ---------------- VS held high ----------------
        do_reset();
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (3) send_frame(-1, -1, 1'b0, 1'b0);
        chk("novs_locked", LOCKED, 0);
        chk("novs_done", done_cnt - d0, 0);
        chk("novs_err", err_cnt - e0, 0);
        chk("novs_line_len", LINE_LEN, HP);
        chk("novs_frame_lines", FRAME_LINES, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_receiver.md
Name: vga_frame_receiver

Overview:
Monitor-side receiver for the VGA timing and pixel stream produced by the game's VGA controller. It recovers line and frame structure from VGA_HS, VGA_VS and VGA_BLANK_N, and emits a coordinate-tagged pixel stream. It measures timing against nominal 640x480 values, runs a lock state machine, and produces a per-frame RGB checksum. It is used as the self-checking sink in the ModelSim benches and as a loopback checker on the board.

Parameters:
H_DISP, 640, active pixels per line
V_DISP, 480, active lines per frame
H_PIXELS, 800, total clocks between consecutive HS falling edges
V_LINES, 524, total HS falling edges between consecutive VS falling edges
LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
VGA_CLK  in  1  pixel clock, shared with the transmitter
RESET_N  in  1  asynchronous active-low reset
VGA_HS  in  1  horizontal sync, active low
VGA_VS  in  1  vertical sync, active low
VGA_BLANK_N  in  1  active video flag
VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
PIX_VALID  out  1  registered copy of VGA_BLANK_N
PIX_X  out  11  active pixel index within the line
PIX_Y  out  11  active line index within the frame
PIX_RGB  out  24  {R,G,B}, registered
LINE_LEN  out  11  last measured HS-to-HS period in clocks
FRAME_LINES  out  11  last measured HS-fall count between VS falls
FRAME_SUM  out  32  checksum of the last complete frame
FRAME_DONE  out  1  one-cycle pulse when FRAME_SUM updates
LOCKED  out  1  high in state LOCK
TIMING_ERR  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset: asynchronous on RESET_N=0, with no clock edge needed. All outputs and counters go to 0 and the FSM goes to SEARCH. Assertion mid-frame discards that frame.
- Input stage: all inputs registered once (same clock domain, no synchroniser).
- Edge detection: falls on HS, VS and BLANK_N and rises on BLANK_N are detected by comparing the previous and current registered values.
- Pixel path latency is 1 cycle from the registered inputs.
  - PIX_VALID and PIX_RGB follow the registered BLANK_N and RGB.
  - PIX_X is 0 on the first active pixel of a line and increments each active pixel. It is cleared while BLANK_N=0.
  - PIX_Y is cleared on each VS fall and increments on each BLANK_N fall.
- hcnt: cleared to 1 on each HS fall, otherwise increments, saturating at 2047.
  - On an HS fall, LINE_LEN <= hcnt, but only once a prior HS fall has been seen since reset or lock loss.
- Line counter: cleared on a VS fall and incremented on each HS fall.
  - On a VS fall, FRAME_LINES <= count before this cycle's HS increment.
  - If HS and VS fall in the same cycle, the new count is 1.
- Active run length: counted while BLANK_N=1 and checked on the BLANK_N fall; it must equal H_DISP. Active lines (BLANK_N rises) are counted per frame and must equal V_DISP.
- Checksum: zero-extended {R,G,B} of every active pixel is summed modulo 2^32.
  - On a VS fall outside SEARCH: FRAME_SUM <= sum, FRAME_DONE pulses, and the sum restarts from 0.
  - If the VS fall cycle is itself active, that pixel starts the new sum.
- Frame good: every line length equals H_PIXELS, line count equals V_LINES, every active run equals H_DISP, and active lines equal V_DISP.
- FSM:
  - SEARCH: on a VS fall go to CHECK with good=0.
  - CHECK: on a VS fall, if the frame is good then good++, otherwise good=0. When good reaches LOCK_FRAMES, go to LOCK.
  - LOCK: any bad line length (checked at the HS fall), bad active run, or bad frame (checked at the VS fall) pulses TIMING_ERR, goes to SEARCH and clears the first-HS flag. The coincident VS fall does not start CHECK.
  - LOCKED asserts the cycle after the deciding VS fall.

Decomposition:
- Package vga_timing_pkg holds H_DISP/H_FPORCH/H_SYNC/H_BPORCH/V_* constants, derived H_PIXELS/V_LINES, and the FSM state encoding (SEARCH=0, CHECK=1, LOCK=2). The VGA controller and this block both use it.
- One sub-module, vga_edge_det: registers one input and outputs rise/fall pulses; instantiated four times.

Test Plan:
- Nominal controller with constant RGB=24'h000001 -> FRAME_DONE at the 2nd VS fall, LOCKED=1 one cycle after the 3rd VS fall, FRAME_SUM=307200, LINE_LEN=800, FRAME_LINES=524.
- Locked, ramp RGB -> first active PIX_X=0/PIX_Y=0 and last PIX_X=639/PIX_Y=479; PIX_RGB equals the input two clocks earlier.
- Locked, one line stretched to 801 clocks -> TIMING_ERR pulses one cycle after that HS fall, LOCKED=0, relock at the 3rd following VS fall.
- In CHECK, one active run of 639 pixels -> good cleared and lock delayed by exactly one frame; FRAME_DONE still pulses.
- RESET_N low mid-line -> all outputs 0 before the next VGA_CLK edge; after release, behaves as the first scenario.
- VGA_VS held high -> LOCKED, FRAME_DONE and TIMING_ERR stay 0 indefinitely; LINE_LEN=800.
